branch_seq_ctrl: RTL and testbench

- Sequences control-flow redirection for the 5-stage PA-RISC pipeline from the condition handler's per-cycle outputs (J = branch taken, n_out = nullify delay slot).
- Branches resolve in EX. The delay-slot instruction is then in ID and the wrong-path instruction is in IF.
- The block drives PC selection and the IF squash, and defers a redirect that arrives while the pipeline is stalled.
- It tracks the delay slot through EX so that a nullified slot instruction is killed there.

---
 rtl/branch_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_branch_seq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: sequences control-flow redirection for the 5-stage pipeline.
// A taken branch resolved in EX redirects the PC in the same cycle and squashes
// the wrong-path fetch. A redirect that arrives under stall is deferred until
// the stall releases. The delay slot is tracked through EX so that a nullified
// slot instruction gets its side effects suppressed there.
//
// Optional feature macro: BRANCH_STATS_EN (adds saturating statistics counters).
//
// Ports:
//   i_clk               pipeline clock
//   i_reset             synchronous, active-high reset
//   i_ex_valid          EX holds a valid, un-killed control instruction
//   i_j                 branch taken from condition handler
//   i_n_out             nullify request (already qualified by taken)
//   i_ta                branch target computed in EX
//   i_stall             hazard-unit freeze of IF/ID/EX
//   o_pc_sel            1 = PC loads o_pc_target, 0 = PC+4 (combinational)
//   o_pc_target         redirect address (combinational, 0 when idle)
//   o_if_kill           squash the instruction moving IF->ID (combinational)
//   o_ex_kill           suppress writes of the instruction in EX
//   o_redirect_pending  a stalled taken branch is waiting to redirect
//   o_taken_cnt         (BRANCH_STATS_EN) redirect cycles, saturating
//   o_null_cnt          (BRANCH_STATS_EN) nullified slot exits, saturating
module branch_seq_ctrl #(
   parameter int unsigned AW = 32
`ifdef BRANCH_STATS_EN
   ,parameter int unsigned CW = 16
`endif
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_ex_valid,
   input  logic          i_j,
   input  logic          i_n_out,
   input  logic [AW-1:0] i_ta,
   input  logic          i_stall,
   output logic          o_pc_sel,
   output logic [AW-1:0] o_pc_target,
   output logic          o_if_kill,
   output logic          o_ex_kill,
   output logic          o_redirect_pending
`ifdef BRANCH_STATS_EN
   ,output logic [CW-1:0] o_taken_cnt,
   output logic [CW-1:0] o_null_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_SLOT = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_tgt;
   logic [AW-1:0] w_tgt_nxt;
   logic          r_n;
   logic          w_n_nxt;

   logic          w_fire;
   logic          w_redirect;
   logic [AW-1:0] w_target;
   logic          w_ex_kill;
   logic          w_pending;
   logic          w_null_exit;

   // State, deferred target and slot-nullify flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_tgt   <= '0;
         r_n     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tgt   <= w_tgt_nxt;
         r_n     <= w_n_nxt;
      end
   end

   // A slot instruction that is being killed cannot itself redirect.
   assign w_fire = ((r_state == ST_IDLE) || ((r_state == ST_SLOT) && !r_n))
                   && i_ex_valid && i_j;

   // Next-state and same-cycle redirect outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_tgt_nxt   = r_tgt;
      w_n_nxt     = r_n;
      w_redirect  = 1'b0;
      w_target    = '0;
      w_ex_kill   = 1'b0;
      w_pending   = 1'b0;
      w_null_exit = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_fire) begin
               w_n_nxt = i_n_out;
               if (i_stall) begin
                  w_tgt_nxt   = i_ta;
                  w_state_nxt = ST_PEND;
               end else begin
                  w_redirect  = 1'b1;
                  w_target    = i_ta;
                  w_state_nxt = ST_SLOT;
               end
            end
         end
         ST_PEND: begin
            // The same frozen branch sits in EX, so its live inputs are ignored.
            w_pending = 1'b1;
            if (!i_stall) begin
               w_redirect  = 1'b1;
               w_target    = r_tgt;
               w_state_nxt = ST_SLOT;
            end
         end
         ST_SLOT: begin
            w_ex_kill = r_n;
            if (!i_stall) begin
               if (r_n) begin
                  w_null_exit = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (w_fire) begin
                  // Branch in an un-nullified delay slot: redirect again.
                  w_redirect  = 1'b1;
                  w_target    = i_ta;
                  w_n_nxt     = i_n_out;
                  w_state_nxt = ST_SLOT;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // All outputs are forced quiet while reset is held.
      if (i_reset) begin
         w_redirect  = 1'b0;
         w_target    = '0;
         w_ex_kill   = 1'b0;
         w_pending   = 1'b0;
         w_null_exit = 1'b0;
      end
   end

   assign o_pc_sel           = w_redirect;
   assign o_if_kill          = w_redirect;
   assign o_pc_target        = w_target;
   assign o_ex_kill          = w_ex_kill;
   assign o_redirect_pending = w_pending;

`ifdef BRANCH_STATS_EN
   logic [CW-1:0] r_taken_cnt;
   logic [CW-1:0] r_null_cnt;

   // Saturating event counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_taken_cnt <= '0;
         r_null_cnt  <= '0;
      end else begin
         if (w_redirect && (r_taken_cnt != {CW{1'b1}}))
            r_taken_cnt <= r_taken_cnt + CW'(1);
         if (w_null_exit && (r_null_cnt != {CW{1'b1}}))
            r_null_cnt <= r_null_cnt + CW'(1);
      end
   end

   assign o_taken_cnt = r_taken_cnt;
   assign o_null_cnt  = r_null_cnt;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl: directed plan steps followed by
// randomized cycles, all compared against a behavioural pipeline model.
module tb_branch_seq_ctrl;

   localparam int unsigned AW = 32;
`ifdef BRANCH_STATS_EN
   localparam int unsigned CW = 16;
   localparam int SAT = 65535;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ex_valid = 1'b0;
   logic          j = 1'b0;
   logic          n_out = 1'b0;
   logic [AW-1:0] ta = '0;
   logic          stall = 1'b0;
   logic          pc_sel;
   logic [AW-1:0] pc_target;
   logic          if_kill;
   logic          ex_kill;
   logic          redirect_pending;
`ifdef BRANCH_STATS_EN
   logic [CW-1:0] taken_cnt;
   logic [CW-1:0] null_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Model: a branch frozen in EX awaiting release, and the delay-slot
   // instruction currently occupying EX together with its nullify flag.
   bit            m_frozen = 1'b0;
   logic [AW-1:0] m_frozen_tgt = '0;
   bit            m_slot_in_ex = 1'b0;
   bit            m_slot_null = 1'b0;
   int            m_taken = 0;
   int            m_nulls = 0;

   always #5 clk = ~clk;

   branch_seq_ctrl #(
      .AW(AW)
`ifdef BRANCH_STATS_EN
      ,.CW(CW)
`endif
   ) dut (
      .i_clk              (clk),
      .i_reset            (reset),
      .i_ex_valid         (ex_valid),
      .i_j                (j),
      .i_n_out            (n_out),
      .i_ta               (ta),
      .i_stall            (stall),
      .o_pc_sel           (pc_sel),
      .o_pc_target        (pc_target),
      .o_if_kill          (if_kill),
      .o_ex_kill          (ex_kill),
      .o_redirect_pending (redirect_pending)
`ifdef BRANCH_STATS_EN
      ,.o_taken_cnt       (taken_cnt),
      .o_null_cnt         (null_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One pipeline cycle: drive inputs after the falling edge, check outputs,
   // then advance the model to what the next rising edge should produce.
   task automatic step(input bit rst, input bit ev, input bit jj, input bit nn,
                       input bit st, input logic [AW-1:0] t);
      bit            e_sel;
      logic [AW-1:0] e_tgt;
      bit            e_kill;
      bit            e_pend;
      bit            null_exit;
      bit            taken;
      @(negedge clk);
      reset = rst; ex_valid = ev; j = jj; n_out = nn; stall = st; ta = t;
      #1;
`ifdef BRANCH_STATS_EN
      chk("taken_cnt", AW'(taken_cnt), AW'(m_taken));
      chk("null_cnt", AW'(null_cnt), AW'(m_nulls));
`endif
      e_sel = 1'b0; e_tgt = '0; e_kill = 1'b0; e_pend = 1'b0; null_exit = 1'b0;
      if (rst) begin
         m_frozen = 1'b0; m_frozen_tgt = '0; m_slot_in_ex = 1'b0; m_slot_null = 1'b0;
      end else begin
         e_kill = m_slot_in_ex && m_slot_null;
         e_pend = m_frozen;
         if (m_frozen) begin
            if (!st) begin
               e_sel = 1'b1; e_tgt = m_frozen_tgt;
               m_frozen = 1'b0; m_slot_in_ex = 1'b1;
            end
         end else if (!(m_slot_in_ex && st)) begin
            taken = ev && jj && !(m_slot_in_ex && m_slot_null);
            null_exit = m_slot_in_ex && m_slot_null;
            if (taken && !st) begin
               e_sel = 1'b1; e_tgt = t; m_slot_in_ex = 1'b1; m_slot_null = nn;
            end else if (taken) begin
               m_frozen = 1'b1; m_frozen_tgt = t; m_slot_null = nn;
            end else begin
               m_slot_in_ex = 1'b0;
            end
         end
      end
      chk("pc_sel", AW'(pc_sel), AW'(e_sel));
      chk("if_kill", AW'(if_kill), AW'(e_sel));
      chk("pc_target", pc_target, e_tgt);
      chk("ex_kill", AW'(ex_kill), AW'(e_kill));
      chk("redirect_pending", AW'(redirect_pending), AW'(e_pend));
`ifdef BRANCH_STATS_EN
      if (rst) begin
         m_taken = 0; m_nulls = 0;
      end else begin
         if (e_sel && m_taken < SAT) m_taken++;
         if (null_exit && m_nulls < SAT) m_nulls++;
      end
`endif
   endtask

   initial begin
      // Reset state
      step(1, 0, 0, 0, 0, '0);
      step(1, 1, 1, 1, 0, 32'hdead_beef);
      step(0, 0, 0, 0, 0, '0);

      // Plain taken branch, then slot, then idle
      step(0, 1, 1, 0, 0, 32'h0000_1000);
      step(0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);

      // Nullifying branch; J in the killed slot must not redirect
      step(0, 1, 1, 1, 0, 32'h0000_2000);
      step(0, 1, 1, 0, 0, 32'h0000_7777);
      step(0, 0, 0, 0, 0, '0);

      // Stalled branch, target input changes while frozen
      step(0, 1, 1, 0, 1, 32'h0000_3000);
      step(0, 1, 1, 0, 1, 32'h0000_9999);
      step(0, 1, 1, 0, 1, 32'h0000_9999);
      step(0, 1, 1, 0, 1, 32'h0000_9999);
      step(0, 1, 1, 0, 0, 32'h0000_9999);
      step(0, 0, 0, 0, 0, '0);

      // Branch in an un-nullified delay slot
      step(0, 1, 1, 0, 0, 32'h0000_4000);
      step(0, 1, 1, 0, 0, 32'h0000_5000);
      step(0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);

      // Stall while in the slot, with nullify held across it
      step(0, 1, 1, 1, 0, 32'h0000_6000);
      step(0, 1, 1, 0, 1, 32'h0000_6666);
      step(0, 1, 1, 0, 0, 32'h0000_6666);
      step(0, 0, 0, 0, 0, '0);

      // Reset while a redirect is pending discards it
      step(0, 1, 1, 1, 1, 32'h0000_a000);
      step(0, 0, 0, 0, 1, '0);
      step(1, 0, 0, 0, 1, '0);
      step(0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 40,
              $urandom_range(0, 99) < 30, AW'($urandom));
      end

`ifdef BRANCH_STATS_EN
      // Drive back-to-back taken branches past counter saturation
      step(1, 0, 0, 0, 0, '0);
      for (int i = 0; i < 65537; i++) begin
         step(0, 1, 1, 0, 0, AW'(i));
      end
      step(0, 0, 0, 0, 0, '0);
      chk("taken_cnt_saturated", AW'(taken_cnt), AW'(32'h0000_ffff));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
